uart_cmd_assembler: RTL and testbench

Downstream consumer of the UART receiver. It takes single received bytes (`rdy`/`rx_data`/`clr_rdy` handshake) and assembles them into a 3-byte command frame: 8-bit opcode, then 16-bit data, high byte first. It presents the completed frame atomically to the command-processing logic with a sticky `cmd_rdy` flag. An optional inter-byte timeout resynchronises the framer after a lost byte.

---
 rtl/uart_cmd_assembler.sv | 163 ++++++++++++++++
 tb/tb_uart_cmd_assembler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler: assembles received UART bytes into {opcode, data_hi, data_lo}
// command frames and publishes each completed frame with a sticky cmd_rdy flag.
// Optional inter-byte timeout resync is compiled in with `define UART_CMD_TIMEOUT_EN.
module uart_cmd_assembler #(
   parameter int unsigned TIMEOUT_CYC = 52083
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_rdy,
   input  logic [7:0]  rx_data,
   output logic        clr_rx_rdy,
   output logic [7:0]  cmd,
   output logic [15:0] data,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   output logic        timeout
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned DATA_W = 16;

   typedef enum logic [1:0] {
      S_CMD = 2'd0,
      S_DHI = 2'd1,
      S_DLO = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [BYTE_W-1:0]   r_cmd_shadow;
   logic [BYTE_W-1:0]   r_hi_shadow;
   logic [BYTE_W-1:0]   r_cmd;
   logic [DATA_W-1:0]   r_data;
   logic                r_cmd_rdy;
   logic                r_timeout;
   logic                w_expire;
   logic                w_ld_op;
   logic                w_ld_hi;
   logic                w_complete;
   logic                w_rdy_clr;

   // Every byte presented is consumed in the same cycle.
   assign clr_rx_rdy = rx_rdy;

   assign cmd     = r_cmd;
   assign data    = r_data;
   assign cmd_rdy = r_cmd_rdy;
   assign timeout = r_timeout;

`ifdef UART_CMD_TIMEOUT_EN
   localparam int unsigned CNT_W = 16;

   logic [CNT_W-1:0] r_cnt;

   // Partial frame expires when the idle count would reach TIMEOUT_CYC; a byte in that cycle wins.
   assign w_expire = (r_state != S_CMD) && !rx_rdy &&
                     (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

   // Inter-byte idle counter: counts only while a frame is partially received.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (rx_rdy || w_expire || (w_next == S_CMD)) begin
         r_cnt <= '0;
      end else if (r_state != S_CMD) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end
`else
   logic w_unused_timeout_cyc;

   assign w_unused_timeout_cyc = ^TIMEOUT_CYC;
   assign w_expire             = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_CMD;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state: advance one position per accepted byte, fall back to CMD on expiry.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_CMD: begin
            if (rx_rdy) w_next = S_DHI;
         end
         S_DHI: begin
            if (rx_rdy)        w_next = S_DLO;
            else if (w_expire) w_next = S_CMD;
         end
         S_DLO: begin
            if (rx_rdy)        w_next = S_CMD;
            else if (w_expire) w_next = S_CMD;
         end
         default: w_next = S_CMD;
      endcase
   end

   // Output decode: per-state load strobes for shadows and the published frame.
   always_comb begin
      w_ld_op    = 1'b0;
      w_ld_hi    = 1'b0;
      w_complete = 1'b0;
      case (r_state)
         S_CMD:   w_ld_op    = rx_rdy;
         S_DHI:   w_ld_hi    = rx_rdy;
         S_DLO:   w_complete = rx_rdy;
         default: w_ld_op    = 1'b0;
      endcase
      w_rdy_clr = w_ld_op || clr_cmd_rdy;
   end

   // Shadow registers hold the partial frame; discarded on expiry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd_shadow <= '0;
         r_hi_shadow  <= '0;
      end else if (w_expire) begin
         r_cmd_shadow <= '0;
         r_hi_shadow  <= '0;
      end else begin
         if (w_ld_op) r_cmd_shadow <= rx_data;
         if (w_ld_hi) r_hi_shadow  <= rx_data;
      end
   end

   // Published frame changes atomically only when the third byte arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd  <= '0;
         r_data <= '0;
      end else if (w_complete) begin
         r_cmd  <= r_cmd_shadow;
         r_data <= {r_hi_shadow, rx_data};
      end
   end

   // Sticky ready flag: completion set beats any clear in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd_rdy <= 1'b0;
      end else if (w_complete) begin
         r_cmd_rdy <= 1'b1;
      end else if (w_rdy_clr) begin
         r_cmd_rdy <= 1'b0;
      end
   end

   // One-cycle pulse marking a discarded partial frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_expire;
      end
   end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench for uart_cmd_assembler; honours `define UART_CMD_TIMEOUT_EN.
module tb_uart_cmd_assembler;

   localparam int unsigned TO = 50;
`ifdef UART_CMD_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_rdy;
   logic [7:0]  rx_data;
   logic        clr_rx_rdy;
   logic [7:0]  cmd;
   logic [15:0] data;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        timeout;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: bytes of the frame in progress and idle edges since the last byte.
   logic [7:0]  m_part[$];
   int          m_idle;
   logic [7:0]  m_cmd;
   logic [15:0] m_data;
   logic        m_rdy;
   logic        m_to;

   uart_cmd_assembler #(.TIMEOUT_CYC(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_rdy      (rx_rdy),
      .rx_data     (rx_data),
      .clr_rx_rdy  (clr_rx_rdy),
      .cmd         (cmd),
      .data        (data),
      .cmd_rdy     (cmd_rdy),
      .clr_cmd_rdy (clr_cmd_rdy),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      assert (act === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_part.delete();
      m_idle = 0;
      m_cmd  = 8'h00;
      m_data = 16'h0000;
      m_rdy  = 1'b0;
      m_to   = 1'b0;
   endtask

   // Frame rules applied per rising edge.
   task automatic model_step(input logic v, input logic [7:0] b, input logic c);
      logic done;
      logic opcode;
      done   = 1'b0;
      opcode = 1'b0;
      m_to   = 1'b0;
      if (v) begin
         m_part.push_back(b);
         m_idle = 0;
         opcode = (m_part.size() == 1);
         if (m_part.size() == 3) begin
            m_cmd  = m_part[0];
            m_data = {m_part[1], m_part[2]};
            m_part.delete();
            done = 1'b1;
         end
      end else if (TO_EN && m_part.size() > 0) begin
         m_idle++;
         if (m_idle == int'(TO)) begin
            m_part.delete();
            m_idle = 0;
            m_to   = 1'b1;
         end
      end
      if (done)             m_rdy = 1'b1;
      else if (c || opcode) m_rdy = 1'b0;
   endtask

   task automatic chk_outputs();
      chk("cmd",     32'(cmd),     32'(m_cmd));
      chk("data",    32'(data),    32'(m_data));
      chk("cmd_rdy", 32'(cmd_rdy), 32'(m_rdy));
      chk("timeout", 32'(timeout), 32'(m_to));
   endtask

   // One clock cycle: drive inputs, check the combinational clear, then the registered outputs.
   task automatic tick(input logic v, input logic [7:0] b, input logic c);
      rx_rdy      = v;
      rx_data     = b;
      clr_cmd_rdy = c;
      #1;
      chk("clr_rx_rdy", 32'(clr_rx_rdy), 32'(v));
      @(posedge clk);
      model_step(v, b, c);
      #1;
      chk_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom), 1'b0);
   endtask

   task automatic send(input logic [7:0] b);
      tick(1'b1, b, 1'b0);
   endtask

   task automatic reset_check();
      chk("rst_cmd",     32'(cmd),     32'h00);
      chk("rst_data",    32'(data),    32'h0000);
      chk("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
      chk("rst_timeout", 32'(timeout), 32'h0);
   endtask

   initial begin
      int to_cnt;
      int to_pos;
      rst_n       = 1'b0;
      rx_rdy      = 1'b0;
      rx_data     = 8'h00;
      clr_cmd_rdy = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      reset_check();
      rst_n = 1'b1;
      idle(3);

      // Slow frame with long gaps between bytes.
      send(8'hA5);
      idle(100);
      send(8'h12);
      idle(100);
      send(8'h34);
`ifndef UART_CMD_TIMEOUT_EN
      chk("slow_cmd",  32'(cmd),     32'hA5);
      chk("slow_data", 32'(data),    32'h1234);
      chk("slow_rdy",  32'(cmd_rdy), 32'h1);
`endif
      idle(5);

      // Completion set beats a simultaneous consumer clear.
      send(8'h7A);
      send(8'h8B);
      tick(1'b1, 8'h9C, 1'b1);
      chk("setwins_rdy",  32'(cmd_rdy), 32'h1);
      chk("setwins_data", 32'(data),    32'h8B9C);
      idle(2);
      send(8'h05);
      chk("op_clears_rdy", 32'(cmd_rdy), 32'h0);
      chk("hold_cmd",      32'(cmd),     32'h7A);
      idle(3);
      send(8'h06);
      chk("hold_data", 32'(data), 32'h8B9C);
      send(8'h07);
      chk("new_cmd",  32'(cmd),  32'h05);
      chk("new_data", 32'(data), 32'h0607);
      tick(1'b0, 8'h00, 1'b1);
      chk("clr_ack", 32'(cmd_rdy), 32'h0);

      // Back-to-back bytes.
      send(8'h01);
      send(8'hFF);
      send(8'h00);
      chk("b2b_cmd",  32'(cmd),     32'h01);
      chk("b2b_data", 32'(data),    32'hFF00);
      chk("b2b_rdy",  32'(cmd_rdy), 32'h1);
      idle(2);

      // Byte arriving on the last idle cycle before expiry is still accepted.
      send(8'h21);
      idle(int'(TO) - 1);
      send(8'h22);
      idle(int'(TO) - 1);
      send(8'h23);
      chk("edge_cmd",  32'(cmd),  32'h21);
      chk("edge_data", 32'(data), 32'h2223);
      idle(2);

      // Lost-byte resync.
      send(8'h11);
      send(8'h22);
      to_cnt = 0;
      to_pos = 0;
      for (int i = 1; i <= 60; i++) begin
         tick(1'b0, 8'($urandom), 1'b0);
         if (timeout === 1'b1) begin
            to_cnt++;
            to_pos = i;
         end
      end
      send(8'h33);
`ifdef UART_CMD_TIMEOUT_EN
      chk("to_count", 32'(to_cnt), 32'd1);
      chk("to_pos",   32'(to_pos), 32'(TO));
`else
      chk("to_count", 32'(to_cnt), 32'd0);
      chk("nto_cmd",  32'(cmd),    32'h11);
      chk("nto_data", 32'(data),   32'h2233);
`endif
      send(8'h44);
      send(8'h55);
`ifdef UART_CMD_TIMEOUT_EN
      chk("to_cmd",  32'(cmd),  32'h33);
      chk("to_data", 32'(data), 32'h4455);
`else
      send(8'h66);
      chk("nto_cmd2",  32'(cmd),  32'h44);
      chk("nto_data2", 32'(data), 32'h5566);
`endif
      idle(2);

      // Reset in the middle of a frame.
      send(8'hAA);
      send(8'hBB);
      rx_rdy = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      reset_check();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_check();
      chk("rst_clr_rx_rdy", 32'(clr_rx_rdy), 32'h0);
      rst_n = 1'b1;
      idle(2);
      send(8'h01);
      send(8'h02);
      send(8'h03);
      chk("post_rst_cmd",  32'(cmd),  32'h01);
      chk("post_rst_data", 32'(data), 32'h0203);

      // Randomised traffic against the model.
      for (int f = 0; f < 300; f++) begin
         int gap;
         gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 70)) : int'($urandom_range(0, 6));
         for (int g = 0; g < gap; g++)
            tick(1'b0, 8'($urandom), ($urandom_range(0, 7) == 0));
         tick(1'b1, 8'($urandom), ($urandom_range(0, 7) == 0));
      end
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
